// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//   Shared definitions for the reaction-game slice.
//   - state_t     : random_delay_ctrl sequencer states
//   - LFSR_SEED   : power-on value of the 12-bit Fibonacci LFSR (taps 11^10)
//   - MS_TICK_DIV : clk cycles per millisecond at 50 MHz
//   - cnt_width() : counter width that holds 0..n-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package game_pkg;

    localparam logic [11:0] LFSR_SEED   = 12'hB76;
    localparam int unsigned MS_TICK_DIV = 50000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_WAIT,
        ST_CHECK,
        ST_COUNT,
        ST_FIRE
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ---------------------------------------------------------------------------
// ms_tick_gen
//   Millisecond prescaler. Counts clk cycles while clr is low and emits a
//   one-cycle tick on every TICK_DIV-th cycle. clr synchronously returns the
//   prescaler to zero, so the first tick after clr drops lands exactly
//   TICK_DIV cycles later.
// Ports
//   clk     in  system clock, rising edge
//   reset_n in  asynchronous active-low reset
//   clr     in  synchronous clear (holds the prescaler at zero)
//   tick    out one-cycle pulse every TICK_DIV cycles
// ---------------------------------------------------------------------------
module ms_tick_gen
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV = MS_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = cnt_width(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/random_delay_ctrl.sv
// ---------------------------------------------------------------------------
// random_delay_ctrl
//   Draws a random reaction-game delay from an external LFSR and times it.
//   On start the LFSR is stepped until its value falls in
//   [MIN_DELAY, MAX_DELAY] (zero always rejected); after MAX_DRAWS misses
//   MIN_DELAY is used and fallback is flagged. The accepted delay is then
//   counted in ms ticks and go is raised until ack.
// Ports
//   clk        in  system clock, rising edge
//   reset_n    in  asynchronous active-low reset
//   start      in  request a new delay (sampled only in IDLE)
//   abort      in  cancel any draw/count, returns to IDLE
//   ack        in  game FSM has seen go (only honoured in FIRE)
//   lfsr_step  out one-cycle clock enable to the LFSR
//   lfsr_value in  current LFSR contents
//   delay_ms   out accepted delay in ms
//   busy       out high in DRAW/WAIT/CHECK/COUNT
//   go         out delay expired; held until ack
//   fallback   out MAX_DRAWS exhausted on this request, MIN_DELAY used
// ---------------------------------------------------------------------------
module random_delay_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LFSR_W    = 12,
    parameter int unsigned MIN_DELAY = 500,
    parameter int unsigned MAX_DELAY = 4000,
    parameter int unsigned TICK_DIV  = MS_TICK_DIV,
    parameter int unsigned MAX_DRAWS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              ack,
    output logic              lfsr_step,
    input  logic [LFSR_W-1:0] lfsr_value,
    output logic [LFSR_W-1:0] delay_ms,
    output logic              busy,
    output logic              go,
    output logic              fallback
);

    localparam int unsigned DW = cnt_width(MAX_DRAWS + 1);

    localparam logic [LFSR_W-1:0] MIN_V = LFSR_W'(MIN_DELAY);
    localparam logic [LFSR_W-1:0] MAX_V = LFSR_W'(MAX_DELAY);
    // remaining is preloaded with delay-1 so that the exit test
    // (remaining==0 at a tick) fires on exactly the delay-th tick.
    localparam logic [LFSR_W-1:0] MIN_RELOAD =
        (MIN_DELAY == 0) ? '0 : LFSR_W'(MIN_DELAY - 1);
    localparam logic [DW-1:0] DRAW_LIMIT = DW'(MAX_DRAWS);

    state_t            state, state_nx;
    logic [DW-1:0]     draws;
    logic [LFSR_W-1:0] remaining;
    logic              in_range;
    logic              draws_left;
    logic              ms_tick;
    logic              tick_clr;

    // The prescaler sits at zero in every state but COUNT, so COUNT entry
    // always starts a full TICK_DIV period.
    assign tick_clr = (state != ST_COUNT);

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (tick_clr),
        .tick   (ms_tick)
    );

    always_comb begin
        in_range   = (lfsr_value != '0) &&
                     (lfsr_value >= MIN_V) && (lfsr_value <= MAX_V);
        draws_left = (draws < DRAW_LIMIT);
    end

    // Moore outputs: an async reset or abort drops them with the state.
    always_comb begin
        lfsr_step = (state == ST_DRAW);
        go        = (state == ST_FIRE);
        busy      = (state == ST_DRAW) || (state == ST_WAIT) ||
                    (state == ST_CHECK) || (state == ST_COUNT);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_DRAW;
            ST_DRAW:  state_nx = ST_WAIT;
            ST_WAIT:  state_nx = ST_CHECK;
            ST_CHECK: begin
                if (in_range)        state_nx = ST_COUNT;
                else if (draws_left) state_nx = ST_DRAW;
                else                 state_nx = ST_COUNT;
            end
            ST_COUNT: if (ms_tick && remaining == '0) state_nx = ST_FIRE;
            ST_FIRE:  if (ack) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (abort) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            draws     <= '0;
            delay_ms  <= '0;
            fallback  <= 1'b0;
            remaining <= '0;
        end else if (!abort) begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        draws    <= '0;
                        fallback <= 1'b0;
                    end
                end
                ST_DRAW: draws <= draws + 1'b1;
                ST_CHECK: begin
                    if (in_range) begin
                        delay_ms  <= lfsr_value;
                        remaining <= lfsr_value - 1'b1;
                    end else if (!draws_left) begin
                        delay_ms  <= MIN_V;
                        remaining <= MIN_RELOAD;
                        fallback  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (ms_tick && remaining != '0) remaining <= remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_random_delay_ctrl.sv
module tb_random_delay_ctrl;
    import game_pkg::*;

    localparam int unsigned TD = 4;
    localparam int unsigned MIN_A [3] = '{500, 2000, 600};
    localparam int unsigned MAX_A [3] = '{4000, 4000, 600};
    localparam int unsigned DRW_A [3] = '{16, 16, 3};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start [3];
    logic        abort [3];
    logic        ack   [3];
    logic        step  [3];
    logic        busy  [3];
    logic        go    [3];
    logic        fb    [3];
    logic [11:0] dly   [3];
    logic [11:0] lfsr_q[3];
    logic        ld    [3];
    logic [11:0] ld_val[3];
    int unsigned step_cnt[3] = '{0, 0, 0};
    int unsigned cyc = 0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [11:0] m_st[3];

    always #5 clk = ~clk;

    function automatic logic [11:0] lfsr_next(input logic [11:0] v);
        return {v[10:0], v[11] ^ v[10]};
    endfunction

    // Bench-side LFSR for each DUT, clock-enabled by that DUT's lfsr_step.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (ld[i])        lfsr_q[i] <= ld_val[i];
            else if (step[i]) lfsr_q[i] <= lfsr_next(lfsr_q[i]);
            if (step[i]) step_cnt[i] <= step_cnt[i] + 1;
        end
    end

    random_delay_ctrl #(.LFSR_W(12), .MIN_DELAY(500), .MAX_DELAY(4000),
                        .TICK_DIV(TD), .MAX_DRAWS(16)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort[0]),
        .ack(ack[0]), .lfsr_step(step[0]), .lfsr_value(lfsr_q[0]),
        .delay_ms(dly[0]), .busy(busy[0]), .go(go[0]), .fallback(fb[0]));

    random_delay_ctrl #(.LFSR_W(12), .MIN_DELAY(2000), .MAX_DELAY(4000),
                        .TICK_DIV(TD), .MAX_DRAWS(16)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort[1]),
        .ack(ack[1]), .lfsr_step(step[1]), .lfsr_value(lfsr_q[1]),
        .delay_ms(dly[1]), .busy(busy[1]), .go(go[1]), .fallback(fb[1]));

    random_delay_ctrl #(.LFSR_W(12), .MIN_DELAY(600), .MAX_DELAY(600),
                        .TICK_DIV(TD), .MAX_DRAWS(3)) u_c (
        .clk(clk), .reset_n(reset_n), .start(start[2]), .abort(abort[2]),
        .ack(ack[2]), .lfsr_step(step[2]), .lfsr_value(lfsr_q[2]),
        .delay_ms(dly[2]), .busy(busy[2]), .go(go[2]), .fallback(fb[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Reference: step the LFSR until a value lies in range (zero never does);
    // after max_d misses the delay is mn with fallback.
    task automatic model_draw(input logic [11:0] st_in, input int unsigned mn,
                              input int unsigned mx, input int unsigned max_d,
                              output int unsigned d, output int unsigned k,
                              output bit fb_e, output logic [11:0] st_out);
        logic [11:0] st;
        bit found;
        st = st_in; found = 0; d = mn; k = max_d; fb_e = 1;
        for (int unsigned n = 1; n <= max_d; n++) begin
            if (!found) begin
                st = lfsr_next(st);
                if (st != 0 && st >= mn && st <= mx) begin
                    found = 1; d = st; k = n; fb_e = 0;
                end
            end
        end
        st_out = st;
    endtask

    // Full request: start, then expect go exactly at N + 3*draws + delay*TD.
    task automatic run_req(input int i, input bit ack_noise);
        int unsigned d, k, n, s0, exp_go;
        bit fb_e;
        model_draw(m_st[i], MIN_A[i], MAX_A[i], DRW_A[i], d, k, fb_e, m_st[i]);
        s0 = step_cnt[i];
        start[i] = 1'b1;
        nxt();
        n = cyc;
        start[i] = 1'b0;
        chk($sformatf("u%0d step after start", i), 32'(step[i]), 1);
        chk($sformatf("u%0d busy after start", i), 32'(busy[i]), 1);
        exp_go = n + 3 * k + d * TD;
        while (go[i] !== 1'b1 && cyc < exp_go + 50) begin
            ack[i] = ack_noise && ($urandom_range(0, 15) == 0);
            nxt();
        end
        ack[i] = 1'b0;
        chk($sformatf("u%0d go rises", i), 32'(go[i]), 1);
        chk($sformatf("u%0d go cycle", i), cyc, exp_go);
        chk($sformatf("u%0d delay_ms", i), 32'(dly[i]), d);
        chk($sformatf("u%0d fallback", i), 32'(fb[i]), 32'(fb_e));
        chk($sformatf("u%0d lfsr steps", i), step_cnt[i] - s0, k);
        chk($sformatf("u%0d busy in fire", i), 32'(busy[i]), 0);
    endtask

    task automatic release_go(input int i);
        ack[i] = 1'b1;
        nxt();
        ack[i] = 1'b0;
        chk($sformatf("u%0d go after ack", i), 32'(go[i]), 0);
        chk($sformatf("u%0d busy after ack", i), 32'(busy[i]), 0);
    endtask

    initial begin
        int unsigned d, k, r;
        bit fb_e;
        for (int i = 0; i < 3; i++) begin
            start[i] = 0; abort[i] = 0; ack[i] = 0;
            ld[i] = 1; ld_val[i] = LFSR_SEED; m_st[i] = LFSR_SEED;
        end
        reset_n = 1'b0;
        nxt();
        for (int i = 0; i < 3; i++) ld[i] = 0;
        nxt();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d reset busy", i), 32'(busy[i]), 0);
            chk($sformatf("u%0d reset go", i), 32'(go[i]), 0);
            chk($sformatf("u%0d reset step", i), 32'(step[i]), 0);
            chk($sformatf("u%0d reset delay", i), 32'(dly[i]), 0);
            chk($sformatf("u%0d reset fallback", i), 32'(fb[i]), 0);
        end
        reset_n = 1'b1;
        nxt();

        // abort wins over start in IDLE
        start[0] = 1; abort[0] = 1;
        nxt();
        start[0] = 0; abort[0] = 0;
        chk("idle abort+start busy", 32'(busy[0]), 0);
        chk("idle abort+start step", 32'(step[0]), 0);

        // defaults: single draw 0x6ED
        run_req(0, 1'b0);
        chk("first delay is 1773", 32'(dly[0]), 1773);

        // go held without ack; start ignored in FIRE
        for (int c = 0; c < 10; c++) begin
            start[0] = 1'($urandom_range(0, 1));
            nxt();
            chk("hold go", 32'(go[0]), 1);
            chk("hold busy", 32'(busy[0]), 0);
            chk("hold step", 32'(step[0]), 0);
        end
        start[0] = 0;
        release_go(0);
        nxt();
        chk("idle after ack", 32'(busy[0]), 0);

        // MIN_DELAY=2000: two draws, stray acks during the count
        run_req(1, 1'b1);
        chk("u1 delay is 3547", 32'(dly[1]), 3547);
        release_go(1);

        // MIN=MAX=600, three draws -> fallback
        run_req(2, 1'b0);
        chk("u2 fallback delay", 32'(dly[2]), 600);
        release_go(2);

        // abort at a random point in COUNT
        model_draw(m_st[0], MIN_A[0], MAX_A[0], DRW_A[0], d, k, fb_e, m_st[0]);
        start[0] = 1;
        nxt();
        start[0] = 0;
        r = $urandom_range(0, 2000);
        repeat (3 * k + r) nxt();
        chk("pre-abort busy", 32'(busy[0]), 1);
        abort[0] = 1;
        nxt();
        abort[0] = 0;
        chk("abort busy", 32'(busy[0]), 0);
        chk("abort go", 32'(go[0]), 0);
        chk("abort step", 32'(step[0]), 0);
        chk("abort delay holds", 32'(dly[0]), d);
        repeat (5) nxt();
        chk("stays idle after abort", 32'(busy[0]), 0);

        // redraw continues from the current LFSR state
        run_req(0, 1'b1);
        release_go(0);

        // async reset in the middle of DRAW
        start[0] = 1;
        nxt();
        start[0] = 0;
        chk("draw before reset", 32'(step[0]), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset step", 32'(step[0]), 0);
        chk("async reset busy", 32'(busy[0]), 0);
        chk("async reset delay", 32'(dly[0]), 0);
        chk("async reset fallback u2", 32'(fb[2]), 0);
        nxt();
        reset_n = 1'b1;
        nxt();
        chk("lfsr not stepped by reset draw", 32'(lfsr_q[0]), 32'(m_st[0]));

        // locked LFSR: zero is rejected every time -> fallback to 500
        ld[0] = 1; ld_val[0] = '0;
        nxt();
        ld[0] = 0;
        m_st[0] = '0;
        run_req(0, 1'b0);
        chk("locked lfsr fallback", 32'(fb[0]), 1);
        release_go(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
